// File: rtl/stopwatch_pkg.sv
// Shared state encoding, digit-select codes and width helper for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  localparam logic [2:0] SEL_UNITS = 3'b101;
  localparam logic [2:0] SEL_TENS  = 3'b100;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and one-cycle rising-edge press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int DW = cw(DEB_CYCLES);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive synced samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        level_d = sync_q;
        press_d = sync_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the 00-99 counter, plus 7-seg digit scan and pause blink.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = 2097152,
  parameter int SCAN_DIV    = 131072,
  parameter int DEB_CYCLES  = 65536,
  parameter int BLINK_SCANS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       carry,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [2:0] seg7_sel,
  output logic       digit_sel,
  output logic       blank,
  output logic [1:0] state_out
);

  localparam int TW = cw(TICK_DIV);
  localparam int SW = cw(SCAN_DIV);
  localparam int BW = cw(BLINK_SCANS);

  logic run_p, clr_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst_n(reset), .btn(btn_run), .press(run_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst_n(reset), .btn(btn_clr), .press(clr_p)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [2:0]    sel_q, sel_d;
  logic          dsel_q, dsel_d;
  logic          blank_q, blank_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          tick, scan_wrap;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_clr_d = clr_p;
    tick      = (state_q == ST_RUN) && (presc_q == TW'(TICK_DIV - 1));

    // Clear outranks everything, including a simultaneous run press.
    if (clr_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (run_p) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && carry) state_d = ST_FULL;
          else if (run_p)    state_d = ST_PAUSE;
        end
        ST_PAUSE: if (run_p) state_d = ST_RUN;
        default: ;
      endcase
    end

    cnt_en_d = tick && !carry && !clr_p;

    if (clr_p || state_q == ST_IDLE) presc_d = '0;
    else if (state_q == ST_RUN)      presc_d = tick ? '0 : presc_q + TW'(1);

    scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    sel_d     = sel_q;
    if (scan_wrap) sel_d = (sel_q == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
    dsel_d    = (sel_d == SEL_TENS);

    // Blink phase restarts on every entry to PAUSE with the display blanked.
    blank_d = 1'b0;
    blink_d = '0;
    if (state_d == ST_PAUSE) begin
      if (state_q != ST_PAUSE) begin
        blank_d = 1'b1;
      end else begin
        blank_d = blank_q;
        blink_d = blink_q;
        if (scan_wrap) begin
          if (blink_q == BW'(BLINK_SCANS - 1)) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      scan_q    <= '0;
      blink_q   <= '0;
      sel_q     <= SEL_UNITS;
      dsel_q    <= 1'b0;
      blank_q   <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      blink_q   <= blink_d;
      sel_q     <= sel_d;
      dsel_q    <= dsel_d;
      blank_q   <= blank_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign seg7_sel  = sel_q;
  assign digit_sel = dsel_q;
  assign blank     = blank_q;
  assign state_out = state_q;

endmodule
